// File: rtl/eth_img_pkg.sv
// Shared definitions for the Ethernet image link (depacketizer and packetizer).
//   IMG_FRAME_HEAD : frame-start marker word carried as word1 of a header packet
//   MAX_H / MAX_V  : default largest accepted frame resolution
//   state_e        : depacketizer FSM states
package eth_img_pkg;

    localparam logic [31:0] IMG_FRAME_HEAD = 32'hF05A_A50F;
    localparam logic [15:0] MAX_H          = 16'd960;
    localparam logic [15:0] MAX_V          = 16'd540;

    typedef enum logic [2:0] {
        StIdle,
        StSeq,
        StHead,
        StRes,
        StPixHi,
        StPixLo,
        StDrop
    } state_e;

endpackage

// File: rtl/eth_img_depkt.sv
// UDP-payload to RGB565 pixel-stream depacketizer.
//   cam_pclk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   rx_valid/rx_data/rx_sop/rx_ready : payload words from the upstream FIFO
//   img_frame_start    : pulse when a valid frame header is accepted
//   img_data_en/img_data : pixel strobe and RGB565 pixel (held while idle)
//   img_h_res/img_v_res  : resolution of the current frame
//   img_frame_done     : pulse coincident with the last pixel of a frame
//   seq_err/hdr_err    : error pulses; drop_cnt counts abandoned frames (saturating)
module eth_img_depkt
    import eth_img_pkg::*;
#(
    parameter logic [31:0] IMG_FRAME_HEAD = eth_img_pkg::IMG_FRAME_HEAD,
    parameter logic [15:0] MAX_H          = eth_img_pkg::MAX_H,
    parameter logic [15:0] MAX_V          = eth_img_pkg::MAX_V
) (
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    input  logic        rx_sop,
    output logic        rx_ready,
    output logic        img_frame_start,
    output logic        img_data_en,
    output logic [15:0] img_data,
    output logic [15:0] img_h_res,
    output logic [15:0] img_v_res,
    output logic        img_frame_done,
    output logic        seq_err,
    output logic        hdr_err,
    output logic [15:0] drop_cnt
);

    state_e      state_q, state_d;
    logic        run_q;
    logic [31:0] seq_q, seq_d;
    logic [31:0] exp_seq_q, exp_seq_d;
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic [31:0] total_q, total_d;
    logic [15:0] lo_q, lo_d;
    logic        hdr_pend_q, hdr_pend_d;
    logic [15:0] data_q, data_d;
    logic        en_q, en_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic        serr_q, serr_d;
    logic        herr_q, herr_d;
    logic [15:0] h_q, h_d;
    logic [15:0] v_q, v_d;
    logic [15:0] drop_q, drop_d;

    logic        accept;
    logic [15:0] res_h, res_v;
    logic        res_bad;
    logic        seq_ok;
    logic        is_head;
    logic        last_pix;
    logic [15:0] drop_inc;

    assign res_h    = rx_data[31:16];
    assign res_v    = rx_data[15:0];
    assign res_bad  = (res_h == 16'd0) || (res_v == 16'd0) || (res_h > MAX_H) || (res_v > MAX_V);
    assign seq_ok   = (rx_data == exp_seq_q);
    assign is_head  = (rx_data == IMG_FRAME_HEAD);
    assign last_pix = (pix_cnt_q == total_q - 32'd1);
    assign drop_inc = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
    assign accept   = rx_valid && rx_ready;

    // run_q holds rx_ready low until the first clock edge after reset release.
    assign rx_ready = run_q && (state_q != StPixLo);

    // State register
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && rx_sop) state_d = StHead;
            StHead: if (accept) state_d = rx_sop ? StHead : (is_head ? StRes : StIdle);
            StRes:  if (accept) state_d = rx_sop ? StHead : (res_bad ? StIdle : StPixHi);
            // StSeq behaves like StPixHi, but its first data word may be a new frame header.
            StPixHi, StSeq: begin
                if (accept) begin
                    if (rx_sop) begin
                        state_d = seq_ok ? StSeq : StDrop;
                    end else if (state_q == StSeq && is_head) begin
                        state_d = StRes;
                    end else if (last_pix) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StPixLo;
                    end
                end
            end
            StPixLo: state_d = last_pix ? StIdle : StPixHi;
            StDrop:  if (accept && !rx_sop && hdr_pend_q && is_head) state_d = StRes;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        seq_d      = seq_q;
        exp_seq_d  = exp_seq_q;
        pix_cnt_d  = pix_cnt_q;
        total_d    = total_q;
        lo_d       = lo_q;
        hdr_pend_d = hdr_pend_q;
        data_d     = data_q;
        h_d        = h_q;
        v_d        = v_q;
        drop_d     = drop_q;
        en_d       = 1'b0;
        start_d    = 1'b0;
        done_d     = 1'b0;
        serr_d     = 1'b0;
        herr_d     = 1'b0;
        unique case (state_q)
            StIdle, StHead: if (accept && rx_sop) seq_d = rx_data;
            StRes: begin
                if (accept) begin
                    if (rx_sop) begin
                        seq_d = rx_data;
                    end else if (res_bad) begin
                        herr_d = 1'b1;
                    end else begin
                        h_d       = res_h;
                        v_d       = res_v;
                        total_d   = {16'd0, res_h} * {16'd0, res_v};
                        exp_seq_d = seq_q + 32'd1;
                        pix_cnt_d = 32'd0;
                        start_d   = 1'b1;
                    end
                end
            end
            StPixHi, StSeq: begin
                if (accept) begin
                    if (rx_sop) begin
                        seq_d = rx_data;
                        if (seq_ok) begin
                            exp_seq_d = exp_seq_q + 32'd1;
                        end else begin
                            serr_d     = 1'b1;
                            drop_d     = drop_inc;
                            hdr_pend_d = 1'b1;  // this packet's word1 may already be a header
                        end
                    end else if (state_q == StSeq && is_head) begin
                        drop_d = drop_inc;      // open frame abandoned for a new header
                    end else begin
                        data_d    = rx_data[31:16];
                        lo_d      = rx_data[15:0];
                        en_d      = 1'b1;
                        done_d    = last_pix;
                        pix_cnt_d = pix_cnt_q + 32'd1;
                    end
                end
            end
            StPixLo: begin
                data_d    = lo_q;
                en_d      = 1'b1;
                done_d    = last_pix;
                pix_cnt_d = pix_cnt_q + 32'd1;
            end
            StDrop: begin
                if (accept) begin
                    if (rx_sop) begin
                        seq_d      = rx_data;
                        hdr_pend_d = 1'b1;
                    end else begin
                        hdr_pend_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            seq_q      <= '0;
            exp_seq_q  <= '0;
            pix_cnt_q  <= '0;
            total_q    <= '0;
            lo_q       <= '0;
            hdr_pend_q <= 1'b0;
            data_q     <= '0;
            en_q       <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            serr_q     <= 1'b0;
            herr_q     <= 1'b0;
            h_q        <= '0;
            v_q        <= '0;
            drop_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            seq_q      <= seq_d;
            exp_seq_q  <= exp_seq_d;
            pix_cnt_q  <= pix_cnt_d;
            total_q    <= total_d;
            lo_q       <= lo_d;
            hdr_pend_q <= hdr_pend_d;
            data_q     <= data_d;
            en_q       <= en_d;
            start_q    <= start_d;
            done_q     <= done_d;
            serr_q     <= serr_d;
            herr_q     <= herr_d;
            h_q        <= h_d;
            v_q        <= v_d;
            drop_q     <= drop_d;
        end
    end

    assign img_frame_start = start_q;
    assign img_data_en     = en_q;
    assign img_data        = data_q;
    assign img_h_res       = h_q;
    assign img_v_res       = v_q;
    assign img_frame_done  = done_q;
    assign seq_err         = serr_q;
    assign hdr_err         = herr_q;
    assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_eth_img_depkt.sv
// Scoreboard bench for eth_img_depkt: the driver pushes expected pixels computed from
// the packet contents, a negedge monitor pops and compares each emitted pixel.
module tb_eth_img_depkt;

    localparam logic [31:0] HEAD = 32'hF05A_A50F;

    logic        cam_pclk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_sop;
    logic        rx_ready;
    logic        img_frame_start;
    logic        img_data_en;
    logic [15:0] img_data;
    logic [15:0] img_h_res;
    logic [15:0] img_v_res;
    logic        img_frame_done;
    logic        seq_err;
    logic        hdr_err;
    logic [15:0] drop_cnt;

    eth_img_depkt dut (
        .cam_pclk        (cam_pclk),
        .rst_n           (rst_n),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_sop          (rx_sop),
        .rx_ready        (rx_ready),
        .img_frame_start (img_frame_start),
        .img_data_en     (img_data_en),
        .img_data        (img_data),
        .img_h_res       (img_h_res),
        .img_v_res       (img_v_res),
        .img_frame_done  (img_frame_done),
        .seq_err         (seq_err),
        .hdr_err         (hdr_err),
        .drop_cnt        (drop_cnt)
    );

    always #5 cam_pclk = ~cam_pclk;

    typedef struct packed {
        logic [15:0] pix;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_start = 0, n_done = 0, n_serr = 0, n_herr = 0;
    int          s_start, s_done, s_serr, s_herr;
    logic [15:0] last_data = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor
    always @(negedge cam_pclk) begin
        if (!rst_n) begin
            last_data = 16'd0;
        end else begin
            if (img_frame_start) n_start++;
            if (img_frame_done)  n_done++;
            if (seq_err)         n_serr++;
            if (hdr_err)         n_herr++;
            if (img_data_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected pixel: got %h, required no pixel", img_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pixel data", {16'd0, img_data}, {16'd0, e.pix});
                    check("frame_done with pixel", {31'd0, img_frame_done}, {31'd0, e.last});
                    last_data = e.pix;
                end
            end else begin
                check("frame_done without pixel", {31'd0, img_frame_done}, 32'd0);
                check("img_data hold", {16'd0, img_data}, {16'd0, last_data});
            end
        end
    end

    function automatic logic [31:0] rand_word();
        logic [31:0] x;
        do x = $urandom; while (x == HEAD);
        return x;
    endfunction

    // Reference: pixel i of a frame is half (i % 2) of pixel word i / 2; H*V pixels per frame.
    task automatic expect_frame(input int h, input int v, input logic [31:0] w[$],
                                input int max_pix);
        int total = h * v;
        int n     = w.size() * 2;
        exp_t e;
        if (n > total) n = total;
        if (max_pix >= 0 && n > max_pix) n = max_pix;
        for (int i = 0; i < n; i++) begin
            e.pix  = (i % 2 == 0) ? w[i / 2][31:16] : w[i / 2][15:0];
            e.last = (i == total - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic s);
        int budget = 200;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge cam_pclk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = d;
        rx_sop   = s;
        forever begin
            @(negedge cam_pclk);
            if (rx_ready) begin
                @(posedge cam_pclk);
                #1;
                break;
            end
            budget--;
            if (budget == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_ready timeout: got 0 for 200 cycles, required 1");
                break;
            end
        end
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] seq, input int h, input int v);
        send_word(seq, 1'b1);
        send_word(HEAD, 1'b0);
        send_word({h[15:0], v[15:0]}, 1'b0);
    endtask

    task automatic send_words(input logic [31:0] w[$], input int from, input int to);
        for (int i = from; i < to; i++) send_word(w[i], 1'b0);
    endtask

    task automatic begin_scn();
        s_start = n_start;
        s_done  = n_done;
        s_serr  = n_serr;
        s_herr  = n_herr;
    endtask

    task automatic end_scn(input string name, input int st, input int dn, input int se,
                           input int he, input int dc);
        int n = 0;
        while (exp_q.size() != 0 && n < 10000) begin
            @(posedge cam_pclk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d pixels pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge cam_pclk);
        #1;
        check({name, " frame_start count"}, n_start - s_start, st);
        check({name, " frame_done count"}, n_done - s_done, dn);
        check({name, " seq_err count"}, n_serr - s_serr, se);
        check({name, " hdr_err count"}, n_herr - s_herr, he);
        check({name, " drop_cnt"}, {16'd0, drop_cnt}, dc);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({name, " img_data_en"}, {31'd0, img_data_en}, 32'd0);
        check({name, " img_data"}, {16'd0, img_data}, 32'd0);
        check({name, " img_h_res"}, {16'd0, img_h_res}, 32'd0);
        check({name, " img_v_res"}, {16'd0, img_v_res}, 32'd0);
        check({name, " drop_cnt"}, {16'd0, drop_cnt}, 32'd0);
        check({name, " pulses"},
              {27'd0, img_frame_start, img_frame_done, seq_err, hdr_err, 1'b0}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge cam_pclk);
        rst_n = 1'b1;
        #1;
        check("rx_ready before first edge", {31'd0, rx_ready}, 32'd0);
        @(posedge cam_pclk);
        #1;
        check("rx_ready after first edge", {31'd0, rx_ready}, 32'd1);
    endtask

    logic [31:0] w[$];
    int          bad_h[4] = '{961, 0, 4, 4};
    int          bad_v[4] = '{2, 2, 0, 541};

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 32'd0;
        rx_sop   = 1'b0;
        repeat (3) @(posedge cam_pclk);
        #1;
        check_reset_outputs("reset");
        release_reset();

        // 4x2 frame with fixed pixel words
        begin_scn();
        w = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        expect_frame(4, 2, w, -1);
        send_hdr(32'd1, 4, 2);
        send_words(w, 0, 4);
        end_scn("frame4x2", 1, 1, 0, 0, 0);
        check("h_res 4", {16'd0, img_h_res}, 32'd4);
        check("v_res 2", {16'd0, img_v_res}, 32'd2);

        // 960x2 frame across two packets, seq 5 then 6
        begin_scn();
        w.delete();
        for (int i = 0; i < 960; i++) w.push_back(rand_word());
        expect_frame(960, 2, w, -1);
        send_hdr(32'd5, 960, 2);
        send_words(w, 0, 500);
        send_word(32'd6, 1'b1);
        send_words(w, 500, 960);
        end_scn("frame960x2", 1, 1, 0, 0, 0);
        check("h_res 960", {16'd0, img_h_res}, 32'd960);

        // Largest accepted height, odd-width boundary H=1 V=540
        begin_scn();
        w.delete();
        for (int i = 0; i < 270; i++) w.push_back(rand_word());
        expect_frame(1, 540, w, -1);
        send_hdr(32'd100, 1, 540);
        send_words(w, 0, 270);
        end_scn("frame1x540", 1, 1, 0, 0, 0);

        // Sequence error: packet seq 9 where 6 is expected, then a clean frame
        begin_scn();
        w.delete();
        for (int i = 0; i < 3; i++) w.push_back(rand_word());
        expect_frame(8, 2, w, -1);
        send_hdr(32'd5, 8, 2);
        send_words(w, 0, 3);
        send_word(32'd9, 1'b1);
        for (int i = 0; i < 4; i++) send_word(rand_word(), 1'b0);
        w.delete();
        for (int i = 0; i < 4; i++) w.push_back(rand_word());
        expect_frame(4, 2, w, -1);
        send_hdr(32'd30, 4, 2);
        send_words(w, 0, 4);
        end_scn("seq_error", 2, 1, 1, 0, 1);

        // Bad headers: each gives hdr_err only, following words ignored
        for (int k = 0; k < 4; k++) begin
            begin_scn();
            send_hdr(32'd50 + 32'(k), bad_h[k], bad_v[k]);
            send_word(rand_word(), 1'b0);
            send_word(rand_word(), 1'b0);
            end_scn("bad_header", 0, 0, 0, 1, 1);
        end

        // Sequence wrap FFFF_FFFF -> 0000_0000 inside a frame, odd pixel count 2x3
        begin_scn();
        w.delete();
        for (int i = 0; i < 3; i++) w.push_back(rand_word());
        expect_frame(2, 3, w, -1);
        send_hdr(32'hFFFF_FFFE, 2, 3);
        send_words(w, 0, 1);
        send_word(32'hFFFF_FFFF, 1'b1);
        send_words(w, 1, 2);
        send_word(32'h0000_0000, 1'b1);
        send_words(w, 2, 3);
        end_scn("seq_wrap", 1, 1, 0, 0, 1);

        // Odd H*V: low half of the final word discarded
        begin_scn();
        w.delete();
        for (int i = 0; i < 2; i++) w.push_back(rand_word());
        expect_frame(3, 1, w, -1);
        send_hdr(32'd60, 3, 1);
        send_words(w, 0, 2);
        send_word(rand_word(), 1'b0);
        end_scn("odd_frame", 1, 1, 0, 0, 1);

        // New header while a frame is open (sequence still in order)
        begin_scn();
        w.delete();
        for (int i = 0; i < 2; i++) w.push_back(rand_word());
        expect_frame(4, 4, w, -1);
        send_hdr(32'd40, 4, 4);
        send_words(w, 0, 2);
        w.delete();
        w.push_back(rand_word());
        expect_frame(2, 1, w, -1);
        send_hdr(32'd41, 2, 1);
        send_words(w, 0, 1);
        end_scn("restart", 2, 1, 0, 0, 2);
        check("restart h_res", {16'd0, img_h_res}, 32'd2);
        check("restart v_res", {16'd0, img_v_res}, 32'd1);

        // Reset after 3 of 8 pixels
        w.delete();
        for (int i = 0; i < 4; i++) w.push_back(rand_word());
        expect_frame(4, 2, w, 3);
        send_hdr(32'd70, 4, 2);
        send_words(w, 0, 2);
        @(negedge cam_pclk);
        #1;
        rst_n = 1'b0;
        #1;
        check("pixels before reset", exp_q.size(), 32'd0);
        exp_q.delete();
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge cam_pclk);
        release_reset();
        begin_scn();
        w.delete();
        for (int i = 0; i < 4; i++) w.push_back(rand_word());
        expect_frame(4, 2, w, -1);
        send_hdr(32'd77, 4, 2);
        send_words(w, 0, 4);
        end_scn("after_reset", 1, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_img_depkt.md
ETH_IMG_DEPKT -- requirements
Module: eth_img_depkt

Interface
REQ-001 Parameters: IMG_FRAME_HEAD, 32'hF05AA50F, frame-start marker word; MAX_H, 16'd960, largest accepted width; MAX_V, 16'd540, largest accepted height.
REQ-002 cam_pclk  input  1  clock; every flop in the block is clocked on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_valid  input  1  rx_data/rx_sop valid (read side of upstream UDP-payload FIFO, cam_pclk domain).
REQ-005 rx_data  input  32  payload word, byte order as transmitted.
REQ-006 rx_sop  input  1  rx_data is the first word of a UDP payload.
REQ-007 rx_ready  output  1  word accepted when rx_valid & rx_ready.
REQ-008 img_frame_start  output  1  one-cycle pulse, valid frame header accepted.
REQ-009 img_data_en  output  1  img_data valid.
REQ-010 img_data  output  16  RGB565 pixel.
REQ-011 img_h_res, img_v_res  output  16 each  resolution of the current frame.
REQ-012 img_frame_done  output  1  one-cycle pulse with the last pixel of a frame (H*V pixels).
REQ-013 seq_err, hdr_err  output  1 each  one-cycle error pulses.
REQ-014 drop_cnt  output  16  count of dropped frames, saturating at 16'hFFFF.

Function
REQ-015 Packet format: word0 = 32-bit sequence number. In a frame-start packet, word1 = IMG_FRAME_HEAD and word2 = {H[31:16], V[15:0]}. All remaining words are pixel pairs, with pixel {[31:16]} first and {[15:0]} second.
REQ-016 FSM states: IDLE, SEQ, HEAD, RES, PIX_HI, PIX_LO, DROP.
REQ-017 IDLE: rx_ready=1; discard words until rx_sop, then capture seq and go to HEAD.
REQ-018 HEAD: word == IMG_FRAME_HEAD goes to RES; otherwise stay in IDLE (no error, since this is a mid-frame packet with no frame open).
REQ-019 RES: H==0, V==0, H>MAX_H or V>MAX_V causes a hdr_err pulse and returns to IDLE. Otherwise latch img_h_res/img_v_res, pulse img_frame_start, set expected_seq = seq+1, clear pixel counters, and go to PIX_HI.
REQ-020 PIX_HI: accept a word (rx_ready=1) and emit the high pixel the following cycle; then PIX_LO: rx_ready=0 and emit the low pixel. Sustained throughput is 1 word per 2 cycles. Latency from word acceptance to the first img_data_en is 1 cycle.
REQ-021 A word with rx_sop seen in PIX_HI is a sequence word and emits no pixel; rx_data == expected_seq increments expected_seq (32-bit wrap FFFF_FFFF to 0) and continues.
REQ-022 Sequence mismatch in PIX_HI: pulse seq_err, increment drop_cnt, go to DROP.
REQ-023 rx_sop with IMG_FRAME_HEAD as its second word while a frame is open: the old frame is abandoned (drop_cnt+1) and the new header is processed; HEAD/RES checks apply.
REQ-024 DROP: rx_ready=1; discard all words until a packet whose word1 == IMG_FRAME_HEAD, then go to RES.
REQ-025 Pixel counter is 32-bit; img_frame_done pulses on pixel index H*V-1, coincident with its img_data_en. The FSM then goes to IDLE and the remaining words of that packet are discarded.
REQ-026 Odd H*V: the low half of the final word is discarded, with no img_data_en.
REQ-027 rx_valid low in any state: FSM holds, img_data_en=0 (except the pending PIX_LO pixel, which is always emitted).
REQ-028 img_data holds its last value when img_data_en=0.

Reset
REQ-029 Asynchronous assertion of rst_n sets: FSM=IDLE, rx_ready=0, img_data_en=0, img_data=0, img_frame_start=0, img_frame_done=0, seq_err=0, hdr_err=0, img_h_res=0, img_v_res=0, drop_cnt=0, expected_seq=0, pixel counter=0.
REQ-030 Release is synchronised to cam_pclk. rx_ready rises on the first clock edge after release.
REQ-031 Reset mid-frame abandons the frame without incrementing drop_cnt; the first frame after reset requires a full header.

Structure
REQ-032 Shared package eth_img_pkg holds IMG_FRAME_HEAD, the FSM state enum, and MAX_H/MAX_V defaults; the transmit packetizer also uses this package.
REQ-033 Single module, no sub-module. Target 150-300 lines.

Verification
REQ-034 Stimulus: valid frame H=4, V=2 (seq 1, head, {4,2}, 4 pixel words 0x11112222..). Required response: img_frame_start once, 8 img_data_en in order 1111,2222,.., img_frame_done on the 8th, seq_err=0.
REQ-035 Stimulus: two packets seq 5 then 6 carrying a 960x2 frame. Required response: 1920 pixels, no errors; expected_seq ends at 7.
REQ-036 Stimulus: second packet seq 9 when 6 is expected. Required response: seq_err pulse, drop_cnt=1, no pixels until the next header; the next valid frame is output completely.
REQ-037 Stimulus: header with H=961. Required response: hdr_err pulse, no img_frame_start, no pixels.
REQ-038 Stimulus: sequence FFFF_FFFF followed by 0000_0000. Required response: no seq_err.
REQ-039 Stimulus: rst_n low after 3 of 8 pixels. Required response: all outputs return to reset values, drop_cnt=0; a subsequent frame is output fully.
